d_ff: RTL and testbench

//   Single-clock, positive-edge D flip-flop with complementary outputs.

---
 rtl/d_ff.sv | 38 +++
 tb/tb_d_ff.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/d_ff.sv
// d_ff: positive-edge D flip-flop with complementary outputs and synchronous active-high reset.
// Latency: d sampled at rising edge N is visible on q/qb right after edge N (one register stage).
// Backpressure: none; a new value is captured on every rising edge, with no enable or stall.
module d_ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  // Single storage element. qb is derived from it, so q and qb can never disagree.
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  // Next state: reset has priority over d and is only honoured at the clock edge.
  always_comb begin
    q_d = q_q;
    if (reset) begin
      q_d = RESET_VALUE;
    end else begin
      q_d = d;
    end
  end

  // State register: plain rising-edge flop, no asynchronous path, no enable.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  // Outputs come straight off the register; there is no combinational path from d or reset.
  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: tb/tb_d_ff.sv
// Testbench for d_ff: directed scenarios plus a randomized run against a simple reference model.
// Inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
// The expected register value is tracked in the bench from the reset/d values it applied.
module tb_d_ff;

  logic clk;
  logic reset;
  logic d;
  logic q;
  logic qb;

  int errors;
  int checks;

  // Model state: what q must hold after the most recent rising edge.
  logic exp_q;

  d_ff #(
    .WIDTH      (1),
    .RESET_VALUE(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .d    (d),
    .q    (q),
    .qb   (qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply reset/d at the falling edge, advance past the next rising edge, and update the model.
  task automatic step(input logic rst, input logic dv);
    @(negedge clk);
    reset = rst;
    d     = dv;
    @(posedge clk);
    #1;
    exp_q = rst ? 1'b0 : dv;
  endtask

  // Scenario 1: reset across one rising edge with d unknown.
  task automatic test_reset();
    step(1'b1, 1'bx);
    checks++;
    if (q !== 1'b0) begin
      errors++;
      $display("FAIL reset_q: got %b expected 0", q);
    end
    checks++;
    if (qb !== 1'b1) begin
      errors++;
      $display("FAIL reset_qb: got %b expected 1", qb);
    end
  endtask

  // Scenario 2: fixed data sequence 0,1,0,1,1 with reset low.
  task automatic test_data_seq();
    logic [4:0] seq;
    seq = 5'b11010;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, seq[i]);
      checks++;
      if (q !== seq[i] || qb !== ~seq[i]) begin
        errors++;
        $display("FAIL data_seq[%0d]: got q=%b qb=%b expected q=%b qb=%b",
                 i, q, qb, seq[i], ~seq[i]);
      end
    end
  endtask

  // Scenario 3: reset while holding 1 with d=1, then resume with d=0, d=1.
  task automatic test_reset_mid();
    step(1'b0, 1'b1);
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL mid_load: got q=%b expected 1", q);
    end
    step(1'b1, 1'b1);
    checks++;
    if (q !== 1'b0 || qb !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got q=%b qb=%b expected q=0 qb=1", q, qb);
    end
    step(1'b0, 1'b0);
    checks++;
    if (q !== 1'b0) begin
      errors++;
      $display("FAIL mid_resume0: got q=%b expected 0", q);
    end
    step(1'b0, 1'b1);
    checks++;
    if (q !== 1'b1 || qb !== 1'b0) begin
      errors++;
      $display("FAIL mid_resume1: got q=%b qb=%b expected q=1 qb=0", q, qb);
    end
  endtask

  // Scenario 4: d glitches between edges must not reach q.
  task automatic test_d_glitch();
    for (int v = 0; v < 2; v++) begin
      logic held;
      held = v[0];
      step(1'b0, held);
      // Low-phase glitch to the opposite value and back.
      @(negedge clk);
      d = ~held;
      #2;
      d = held;
      #1;
      checks++;
      if (q !== held || qb !== ~held) begin
        errors++;
        $display("FAIL glitch_low[%0d]: got q=%b qb=%b expected q=%b", v, q, qb, held);
      end
      @(posedge clk);
      #1;
      // High-phase glitch right after the edge.
      d = ~held;
      #2;
      checks++;
      if (q !== held) begin
        errors++;
        $display("FAIL glitch_high[%0d]: got q=%b expected %b", v, q, held);
      end
      d = held;
      @(posedge clk);
      #1;
      checks++;
      if (q !== held) begin
        errors++;
        $display("FAIL glitch_after[%0d]: got q=%b expected %b", v, q, held);
      end
    end
    exp_q = d;
  endtask

  // Scenario 5: short reset pulses that never span a rising edge leave q untouched.
  task automatic test_reset_pulse();
    step(1'b0, 1'b1);
    // Pulse in the high phase, just after the edge.
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (q !== 1'b1 || qb !== 1'b0) begin
      errors++;
      $display("FAIL pulse_high: got q=%b qb=%b expected q=1 qb=0", q, qb);
    end
    // Pulse in the low phase, released before the next edge.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL pulse_low: got q=%b expected 1", q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (q !== 1'b1 || qb !== 1'b0) begin
      errors++;
      $display("FAIL pulse_edge: got q=%b qb=%b expected q=1 qb=0", q, qb);
    end
    exp_q = 1'b1;
  endtask

  // Reset held for several cycles with changing d, then the first low-reset edge loads d.
  task automatic test_reset_hold();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i[0]);
      checks++;
      if (q !== 1'b0 || qb !== 1'b1) begin
        errors++;
        $display("FAIL hold[%0d]: got q=%b qb=%b expected q=0 qb=1", i, q, qb);
      end
    end
    step(1'b0, 1'b1);
    checks++;
    if (q !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: got q=%b expected 1", q);
    end
  endtask

  // Back-to-back alternating data every edge.
  task automatic test_back_to_back();
    logic v;
    v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, v);
      checks++;
      if (q !== v) begin
        errors++;
        $display("FAIL b2b[%0d]: got q=%b expected %b", i, q, v);
      end
      v = ~v;
    end
  endtask

  // Randomized reset/d against the model, including mid-cycle stability and qb == ~q every cycle.
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic rst;
      logic dv;
      rst = ($urandom_range(7) == 0);
      dv  = 1'($urandom_range(1));
      step(rst, dv);
      checks++;
      if (q !== exp_q || qb !== ~exp_q) begin
        errors++;
        $display("FAIL random[%0d]: rst=%b d=%b got q=%b qb=%b expected q=%b qb=%b",
                 i, rst, dv, q, qb, exp_q, ~exp_q);
      end
      // Stir the inputs mid-cycle; outputs must hold until the next edge.
      #2;
      reset = 1'($urandom_range(1));
      d     = 1'($urandom_range(1));
      #1;
      checks++;
      if (q !== exp_q || q === qb) begin
        errors++;
        $display("FAIL random_stable[%0d]: got q=%b qb=%b expected q=%b", i, q, qb, exp_q);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_q  = 1'bx;
    reset  = 1'b0;
    d      = 1'b0;

    test_reset();
    test_data_seq();
    test_reset_mid();
    test_d_glitch();
    test_reset_pulse();
    test_reset_hold();
    test_back_to_back();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
